adxl345_iic_master: RTL and testbench

ADXL345_IIC_MASTER -- requirements
Module: adxl345_iic_master

---
 rtl/adxl345_iic_master.sv | 260 ++++++++++++++++++++++++++
 tb/tb_adxl345_iic_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adxl345_iic_master.sv
// I2C register read/write master for an ADXL345 accelerometer (single slave, no clock stretching).
// Each bit slot is four quarters of QTR_DIV clocks: SCL low in q0-q1, high in q2-q3.
module adxl345_iic_master #(
    parameter logic [6:0] DEV_ADDR = 7'h53,
    parameter int         QTR_DIV  = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iicwr_req,
    input  logic       iicrd_req,
    input  logic [7:0] iic_addr,
    input  logic [7:0] iic_wrdb,
    output logic [7:0] iic_rddb,
    output logic       iic_ack,
    output logic       iic_nack_err,
    output logic       iic_busy,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_i
);
    localparam int            DW       = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(QTR_DIV - 1);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        START   = 4'd1,
        TX_BYTE = 4'd2,
        RX_ACK  = 4'd3,
        RSTART  = 4'd4,
        RX_BYTE = 4'd5,
        TX_NACK = 4'd6,
        STOP    = 4'd7,
        DONE    = 4'd8
    } state_t;

    // SDA pull for a given position; only START/STOP move SDA at q2, everything else at q0.
    function automatic logic sda_drive(input state_t st, input logic [1:0] qtr, input logic [7:0] sh);
        logic pull;
        case (st)
            START, RSTART: pull = qtr[1];
            TX_BYTE:       pull = ~sh[7];
            STOP:          pull = ~qtr[1];
            default:       pull = 1'b0;
        endcase
        return pull;
    endfunction

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wrdb_q, wrdb_d;
    logic          rd_q, rd_d;
    logic          nack_q, nack_d;
    logic          armed_q, armed_d;
    logic          ack_bit_q, ack_bit_d;
    logic [7:0]    rddb_q, rddb_d;
    logic          scl_q, scl_d;
    logic          sda_oe_q, sda_oe_d;
    logic          ack_q, ack_d;
    logic          nack_err_q, nack_err_d;
    logic          busy_q, busy_d;
    logic          slot_end_s;
    logic          sample_s;

    assign slot_end_s = (div_q == DIV_LAST) && (qtr_q == 2'd3);
    assign sample_s   = (div_q == DIV_LAST) && (qtr_q == 2'd2);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        wrdb_d    = wrdb_q;
        rd_d      = rd_q;
        nack_d    = nack_q;
        armed_d   = armed_q;
        ack_bit_d = ack_bit_q;
        rddb_d    = rddb_q;

        if ((state_q != IDLE) && (state_q != DONE)) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                qtr_d = qtr_q + 2'd1;
            end else begin
                div_d = div_q + DW'(1);
            end
        end else begin
            div_d = '0;
            qtr_d = 2'd0;
        end

        case (state_q)
            IDLE: begin
                if (!iicwr_req && !iicrd_req) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    state_d = START;
                    addr_d  = iic_addr;
                    wrdb_d  = iic_wrdb;
                    rd_d    = ~iicwr_req;
                    nack_d  = 1'b0;
                    bit_d   = 3'd0;
                    byte_d  = 2'd0;
                    shift_d = {DEV_ADDR, 1'b0};
                end else begin
                    armed_d = 1'b0;
                end
            end
            START: begin
                if (slot_end_s) begin
                    state_d = TX_BYTE;
                    bit_d   = 3'd0;
                end
            end
            TX_BYTE: begin
                if (slot_end_s) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    if (bit_q == 3'd7) begin
                        state_d = RX_ACK;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            RX_ACK: begin
                if (sample_s) begin
                    ack_bit_d = sda_i;
                end
                if (slot_end_s) begin
                    bit_d = 3'd0;
                    if (ack_bit_q) begin
                        nack_d  = 1'b1;
                        state_d = STOP;
                    end else begin
                        // byte_q: 0 = address+W, 1 = register, 2 = write data, 3 = address+R
                        case (byte_q)
                            2'd0: begin
                                state_d = TX_BYTE;
                                shift_d = addr_q;
                                byte_d  = 2'd1;
                            end
                            2'd1: begin
                                if (rd_q) begin
                                    state_d = RSTART;
                                end else begin
                                    state_d = TX_BYTE;
                                    shift_d = wrdb_q;
                                    byte_d  = 2'd2;
                                end
                            end
                            2'd2:    state_d = STOP;
                            default: state_d = RX_BYTE;
                        endcase
                    end
                end
            end
            RSTART: begin
                if (slot_end_s) begin
                    state_d = TX_BYTE;
                    shift_d = {DEV_ADDR, 1'b1};
                    byte_d  = 2'd3;
                    bit_d   = 3'd0;
                end
            end
            RX_BYTE: begin
                if (sample_s) begin
                    shift_d = {shift_q[6:0], sda_i};
                end
                if (slot_end_s) begin
                    if (bit_q == 3'd7) begin
                        state_d = TX_NACK;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            TX_NACK: begin
                if (slot_end_s) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (slot_end_s) begin
                    state_d = DONE;
                    if (rd_q && !nack_q) begin
                        rddb_d = shift_q;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d != IDLE);
        ack_d      = (state_d == DONE);
        nack_err_d = (state_d == DONE) && nack_d;
        scl_d      = ((state_d == IDLE) || (state_d == DONE)) ? 1'b1 : qtr_d[1];
        sda_oe_d   = sda_drive(state_d, qtr_d, shift_d);
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            qtr_q      <= 2'd0;
            bit_q      <= 3'd0;
            byte_q     <= 2'd0;
            shift_q    <= 8'h00;
            addr_q     <= 8'h00;
            wrdb_q     <= 8'h00;
            rd_q       <= 1'b0;
            nack_q     <= 1'b0;
            armed_q    <= 1'b0;
            ack_bit_q  <= 1'b0;
            rddb_q     <= 8'h00;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            ack_q      <= 1'b0;
            nack_err_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            wrdb_q     <= wrdb_d;
            rd_q       <= rd_d;
            nack_q     <= nack_d;
            armed_q    <= armed_d;
            ack_bit_q  <= ack_bit_d;
            rddb_q     <= rddb_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
            ack_q      <= ack_d;
            nack_err_q <= nack_err_d;
            busy_q     <= busy_d;
        end
    end

    assign iic_rddb     = rddb_q;
    assign iic_ack      = ack_q;
    assign iic_nack_err = nack_err_q;
    assign iic_busy     = busy_q;
    assign scl          = scl_q;
    assign sda_oe       = sda_oe_q;

endmodule

// File: tb/tb_adxl345_iic_master.sv
// Directed bench for adxl345_iic_master at QTR_DIV=4 with a bus-level ADXL345 slave model.
module tb_adxl345_iic_master;
    localparam int QD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iicwr_req = 1'b0;
    logic       iicrd_req = 1'b0;
    logic [7:0] iic_addr = 8'h00;
    logic [7:0] iic_wrdb = 8'h00;
    logic [7:0] iic_rddb;
    logic       iic_ack;
    logic       iic_nack_err;
    logic       iic_busy;
    logic       scl;
    logic       sda_oe;
    logic       sda_i;

    adxl345_iic_master #(.DEV_ADDR(7'h53), .QTR_DIV(QD)) dut (
        .clk(clk), .rst(rst), .iicwr_req(iicwr_req), .iicrd_req(iicrd_req),
        .iic_addr(iic_addr), .iic_wrdb(iic_wrdb), .iic_rddb(iic_rddb),
        .iic_ack(iic_ack), .iic_nack_err(iic_nack_err), .iic_busy(iic_busy),
        .scl(scl), .sda_oe(sda_oe), .sda_i(sda_i)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;
    int ack_cnt = 0;

    // Slave model state; the bus is open-drain so either side can pull it low.
    logic       sl_pull = 1'b0;
    logic       sl_next = 1'b0;
    logic       scl_d1 = 1'b1;
    logic       sda_d1 = 1'b1;
    int         sl_phase = 0;
    int         sl_bits = 0;
    logic [7:0] sl_sr = 8'h00;
    logic       sl_first = 1'b0;
    logic       sl_rd = 1'b0;
    logic       sl_nacked = 1'b0;
    logic [6:0] sl_addr = 7'h53;
    logic [7:0] sl_tx = 8'h5A;
    logic       sda_line;
    int         bus_log[$];
    int         exp_log[$];

    assign sda_line = ~sda_oe & ~sl_pull;
    assign sda_i    = sda_line;

    always @(posedge clk) begin
        if (iic_ack === 1'b1) ack_cnt <= ack_cnt + 1;
    end

    // Classify every SCL rising edge by SDA just before and just after it; drive SDA on SCL fall.
    always @(posedge clk) begin
        scl_d1 <= scl;
        sda_d1 <= sda_line;
        if (scl_d1 === 1'b1 && scl === 1'b0) sl_pull <= sl_next;
        if (scl_d1 === 1'b0 && scl === 1'b1) begin
            if (sda_d1 === 1'b1 && sda_line === 1'b0) begin
                bus_log.push_back(1000);
                sl_phase <= 1;
                sl_bits  <= 0;
                sl_first <= 1'b1;
                sl_next  <= 1'b0;
            end else if (sda_d1 === 1'b0 && sda_line === 1'b1) begin
                bus_log.push_back(2000);
                sl_phase <= 0;
                sl_next  <= 1'b0;
            end else begin
                case (sl_phase)
                    1: begin
                        sl_sr   <= {sl_sr[6:0], sda_line};
                        sl_bits <= sl_bits + 1;
                        if (sl_bits == 7) begin
                            sl_phase <= 2;
                            if (sl_first) begin
                                sl_rd     <= sda_line;
                                sl_nacked <= (sl_sr[6:0] != sl_addr);
                                sl_next   <= (sl_sr[6:0] == sl_addr);
                            end else begin
                                sl_nacked <= 1'b0;
                                sl_next   <= 1'b1;
                            end
                        end
                    end
                    2: begin
                        bus_log.push_back({23'd0, sda_line, sl_sr});
                        sl_bits  <= 0;
                        sl_first <= 1'b0;
                        if (sl_nacked) begin
                            sl_phase <= 0;
                            sl_next  <= 1'b0;
                        end else if (sl_first && sl_rd) begin
                            sl_phase <= 3;
                            sl_next  <= ~sl_tx[7];
                        end else begin
                            sl_phase <= 1;
                            sl_next  <= 1'b0;
                        end
                    end
                    3: begin
                        sl_sr   <= {sl_sr[6:0], sda_line};
                        sl_bits <= sl_bits + 1;
                        if (sl_bits == 7) begin
                            sl_phase <= 4;
                            sl_next  <= 1'b0;
                        end else begin
                            sl_next <= ~sl_tx[6 - sl_bits];
                        end
                    end
                    4: begin
                        bus_log.push_back({23'd0, sda_line, sl_sr});
                        sl_phase <= 0;
                        sl_next  <= 1'b0;
                    end
                    default: sl_next <= 1'b0;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, bus_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), (i < bus_log.size()) ? bus_log[i] : -1, exp_log[i]);
        end
    endtask

    int         lat;
    logic [7:0] rddb_at_ack;
    logic       nack_at_ack;
    logic       busy_at_ack;
    logic       busy_first;
    logic       busy_after;

    // Issue one request, time it to iic_ack, then hold the request 'hold' extra cycles before dropping it.
    task automatic run_txn(input logic wr, input logic rd, input logic [7:0] a, input logic [7:0] d, input int hold);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        bus_log.delete();
        @(negedge clk);
        iicwr_req = wr;
        iicrd_req = rd;
        iic_addr  = a;
        iic_wrdb  = d;
        while (!got && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                busy_first = iic_busy;
                iic_addr   = ~a;
                iic_wrdb   = ~d;
            end
            if (iic_ack === 1'b1) begin
                got         = 1'b1;
                rddb_at_ack = iic_rddb;
                nack_at_ack = iic_nack_err;
                busy_at_ack = iic_busy;
            end
        end
        lat = got ? n : -1;
        @(posedge clk);
        #1;
        busy_after = iic_busy;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        iicwr_req = 1'b0;
        iicrd_req = 1'b0;
    endtask

    initial begin
        int acks_before;
        int log_before;

        repeat (5) @(posedge clk);
        #1;
        check("rst_scl", scl, 1);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_ack", iic_ack, 0);
        check("rst_nack", iic_nack_err, 0);
        check("rst_busy", iic_busy, 0);
        check("rst_rddb", iic_rddb, 8'h00);

        // Request already high when reset releases must not start anything.
        @(negedge clk);
        iicwr_req = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("unarmed_busy", iic_busy, 0);
        check("unarmed_scl", scl, 1);
        @(negedge clk);
        iicwr_req = 1'b0;
        repeat (3) @(posedge clk);

        // Write 0x31 <= 0x0B
        run_txn(1'b1, 1'b0, 8'h31, 8'h0B, 0);
        check("wr_lat", lat, 465);
        check("wr_busy_first", busy_first, 1);
        check("wr_busy_ack", busy_at_ack, 1);
        check("wr_busy_after", busy_after, 0);
        check("wr_nack", nack_at_ack, 0);
        exp_log = {1000, 'hA6, 'h31, 'h0B, 2000};
        check_log("wr_bus");

        // Read 0x32, slave returns 0x5A
        run_txn(1'b0, 1'b1, 8'h32, 8'h00, 0);
        check("rd_lat", lat, 625);
        check("rd_rddb", rddb_at_ack, 8'h5A);
        check("rd_nack", nack_at_ack, 0);
        check("rd_busy_after", busy_after, 0);
        exp_log = {1000, 'hA6, 'h32, 1000, 'hA7, 'h15A, 2000};
        check_log("rd_bus");

        // Slave at a different address NACKs the address byte
        sl_addr = 7'h11;
        run_txn(1'b1, 1'b0, 8'h31, 8'h0B, 0);
        sl_addr = 7'h53;
        check("nack_lat", lat, 177);
        check("nack_err", nack_at_ack, 1);
        check("nack_rddb", rddb_at_ack, 8'h5A);
        exp_log = {1000, 'h1A6, 2000};
        check_log("nack_bus");

        // Request held past iic_ack must not retrigger
        run_txn(1'b1, 1'b0, 8'h38, 8'h80, 2);
        check("hold_lat", lat, 465);
        log_before = bus_log.size();
        repeat (40) @(posedge clk);
        #1;
        check("hold_no_restart_busy", iic_busy, 0);
        check("hold_no_restart_bus", bus_log.size(), log_before);

        // Both requests together: write wins
        run_txn(1'b1, 1'b1, 8'h2D, 8'h08, 0);
        check("both_lat", lat, 465);
        exp_log = {1000, 'hA6, 'h2D, 'h08, 2000};
        check_log("both_bus");

        // Reset in slot 12 (bit 5 of register 0x1E is 0, so SDA is pulled there)
        acks_before = ack_cnt;
        @(negedge clk);
        iicwr_req = 1'b1;
        iic_addr  = 8'h1E;
        iic_wrdb  = 8'h08;
        repeat (200) @(posedge clk);
        #1;
        check("slot12_scl", scl, 0);
        check("slot12_sda_oe", sda_oe, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_scl", scl, 1);
        check("abort_sda_oe", sda_oe, 0);
        check("abort_busy", iic_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        iicwr_req = 1'b0;
        repeat (600) @(posedge clk);
        #1;
        check("abort_no_ack", ack_cnt, acks_before);
        check("abort_idle_busy", iic_busy, 0);
        check("abort_rddb", iic_rddb, 8'h00);

        // Recovery after the abort
        run_txn(1'b1, 1'b0, 8'h2C, 8'h0A, 0);
        check("recover_lat", lat, 465);
        exp_log = {1000, 'hA6, 'h2C, 'h0A, 2000};
        check_log("recover_bus");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
